// File: rtl/dmem_loader_pkg.sv
// dmem_loader_pkg
//   Types and constants shared by the loader, its address generator and the
//   data-memory decode.
//   - state_t       : loader FSM state encoding
//   - IO_BIT        : address bit that selects the I/O space (never set by the loader)
//   - word_to_addr  : word index -> byte address inside the data memory
//   - is_io_addr    : decode helper, 1 when an address falls into the I/O space
package dmem_loader_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int IDX_W          = 5;   // 32-word data memory
  localparam int CNT_W          = 6;   // word_count carries 1..32
  localparam int IO_BIT         = 7;   // bus_addr[7]=1 selects I/O space
  localparam int MAX_WORDS_DFLT = 32;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_WAIT  = 3'd1,
    S_LD_WRITE = 3'd2,
    S_DP_ADDR  = 3'd3,
    S_DP_WAIT  = 3'd4,
    S_DP_OUT   = 3'd5,
    S_FINISH   = 3'd6
  } state_t;

  // Word index to byte address. Upper bits, including IO_BIT, stay zero, so
  // any address built here lands in the data memory.
  function automatic logic [ADDR_W-1:0] word_to_addr(input logic [IDX_W-1:0] word);
    return {{(ADDR_W-IDX_W-2){1'b0}}, word, 2'b00};
  endfunction

  // Data-memory / I/O decode.
  function automatic logic is_io_addr(input logic [ADDR_W-1:0] addr);
    return addr[IO_BIT];
  endfunction

endpackage

// File: rtl/dmem_loader_addrgen.sv
// dmem_loader_addrgen
//   Computes the byte address of one transfer word: the word index is the
//   start index plus the running offset, wrapped modulo the 32-word memory.
//   Ports:
//     base_idx : word index of the first word of the transfer
//     idx      : running word offset within the transfer
//     addr     : byte address, always inside the data memory
module dmem_loader_addrgen
  import dmem_loader_pkg::*;
(
  input  logic [IDX_W-1:0]  base_idx,
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr
);

  logic [IDX_W-1:0] word_idx;

  always_comb begin
    // IDX_W-bit sum drops the carry: this is the modulo-32 wrap.
    word_idx = base_idx + idx;
    addr     = word_to_addr(word_idx);
  end

endmodule

// File: rtl/dmem_loader.sv
// dmem_loader
//   Moves a block of 32-bit words between a host stream and the data memory.
//   A load takes word_count words from the in_* stream and writes them to
//   consecutive memory words; a dump reads word_count memory words and offers
//   them on the out_* stream. Word indices wrap inside the 32-word memory, so
//   the I/O space is never addressed.
//   Ports:
//     clock, reset            : clock, asynchronous active-high reset
//     start_load, start_dump  : one-cycle transfer requests (honoured in IDLE only)
//     base_addr, word_count   : transfer byte address and length, sampled at start
//     in_valid/in_data/in_ready    : host -> loader word stream
//     out_valid/out_data/out_ready : loader -> host word stream
//     bus_addr/bus_wdata/bus_we    : data-memory initiator bus
//     bus_rdata               : data-memory read data, READ_LAT cycles after bus_addr
//     busy                    : high whenever the loader is not idle
//     done                    : one-cycle pulse when a transfer completes
//     error                   : one-cycle pulse when a start is rejected
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DFLT,
  parameter int READ_LAT  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Holds READ_LAT-1, minimum one bit.
  localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_t             state;
  logic [IDX_W-1:0]   base_idx_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   count_q;
  logic [WAIT_W-1:0]  wait_q;

  logic               start_any;
  logic               start_bad;
  logic               last_word;

  logic [IDX_W-1:0]   ag_base;
  logic [IDX_W-1:0]   ag_idx;
  logic [ADDR_W-1:0]  ag_addr;

  // Start qualification: misaligned, outside the data memory, empty,
  // oversize, or both kinds requested at once.
  always_comb begin
    start_any = start_load | start_dump;
    start_bad = (start_load & start_dump)
              | (base_addr[1:0] != 2'b00)
              | (base_addr[ADDR_W-1:IO_BIT] != '0)
              | (word_count == '0)
              | ({{(32-CNT_W){1'b0}}, word_count} > 32'(MAX_WORDS));
  end

  always_comb begin
    last_word = ({1'b0, idx_q} == (count_q - CNT_W'(1)));
  end

  // Address generator input select. bus_addr is registered, so the address
  // is computed for the word the next state will present:
  //   IDLE   -> first word of a new dump, using the base straight off the port
  //   DP_OUT -> next word of the dump
  //   others -> current word (LD_WAIT -> LD_WRITE)
  always_comb begin
    ag_base = base_idx_q;
    ag_idx  = idx_q;
    case (state)
      S_IDLE: begin
        ag_base = base_addr[IO_BIT-1:2];
        ag_idx  = '0;
      end
      S_DP_OUT: ag_idx = idx_q + IDX_W'(1);
      default: ;
    endcase
  end

  dmem_loader_addrgen u_addrgen (
    .base_idx (ag_base),
    .idx      (ag_idx),
    .addr     (ag_addr)
  );

  // Transfer FSM; every output is a register updated with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      base_idx_q <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_any) begin
            if (start_bad) begin
              error <= 1'b1;
            end else begin
              base_idx_q <= base_addr[IO_BIT-1:2];
              count_q    <= word_count;
              idx_q      <= '0;
              busy       <= 1'b1;
              if (start_load) begin
                in_ready <= 1'b1;
                state    <= S_LD_WAIT;
              end else begin
                bus_addr <= ag_addr;
                state    <= S_DP_ADDR;
              end
            end
          end
        end

        S_LD_WAIT: begin
          if (in_valid && in_ready) begin
            // bus_wdata doubles as the holding register for the accepted word.
            bus_wdata <= in_data;
            bus_addr  <= ag_addr;
            bus_we    <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_LD_WRITE;
          end
        end

        S_LD_WRITE: begin
          bus_we <= 1'b0;
          if (last_word) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            idx_q    <= idx_q + IDX_W'(1);
            in_ready <= 1'b1;
            state    <= S_LD_WAIT;
          end
        end

        S_DP_ADDR: begin
          wait_q <= WAIT_W'(READ_LAT - 1);
          state  <= S_DP_WAIT;
        end

        S_DP_WAIT: begin
          // bus_addr stays put, so read data for this word is valid in the
          // last wait cycle.
          if (wait_q == '0) begin
            out_data  <= bus_rdata;
            out_valid <= 1'b1;
            state     <= S_DP_OUT;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end

        S_DP_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_word) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              idx_q    <= idx_q + IDX_W'(1);
              bus_addr <= ag_addr;
              state    <= S_DP_ADDR;
            end
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          bus_we    <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
`timescale 1ns/1ps
module tb_dmem_loader;
  import dmem_loader_pkg::*;

  localparam int READ_LAT = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_load = 1'b0;
  logic        start_dump = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic [5:0]  word_count = 6'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  dmem_loader #(.MAX_WORDS(32), .READ_LAT(READ_LAT)) dut (
    .clock(clock), .reset(reset),
    .start_load(start_load), .start_dump(start_dump),
    .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(bus_rdata),
    .busy(busy), .done(done), .error(error)
  );

  // Data memory attached to the DUT bus (environment, not the model).
  logic [31:0] dmem [32];
  logic [31:0] rd_pipe [READ_LAT];
  always @(posedge clock) begin
    if (bus_we) dmem[bus_addr[6:2]] <= bus_wdata;
    rd_pipe[0] <= dmem[bus_addr[6:2]];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus_rdata = rd_pipe[READ_LAT-1];

  // Reference model: memory image plus expected bus writes / output words.
  logic [31:0] ref_mem [32];
  logic [31:0] exp_wa[$], exp_wd[$], exp_od[$];
  logic [31:0] wr_log_a[$], wr_log_d[$], out_log[$];
  logic [31:0] fixed[$];
  int tests = 0, fails = 0;
  int done_seen = 0, exp_done = 0, err_seen = 0, exp_err = 0;
  bit busy_seen = 0;
  bit start_now = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  // Per-cycle compare process.
  initial begin
    logic        prev_ov, prev_or, prev_done;
    logic [31:0] prev_od, prev_ba;
    prev_ov = 0; prev_or = 0; prev_done = 0; prev_od = 0; prev_ba = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_ov = 0; prev_done = 0;
      end else begin
        if (busy) busy_seen = 1;
        check1("io_space", is_io_addr(bus_addr), 1'b0);
        check1("rdy_vld_excl", in_ready & out_valid, 1'b0);
        if (!busy) check("idle_quiet", {29'b0, in_ready, out_valid, bus_we}, 32'h0);
        if (bus_we) begin
          wr_log_a.push_back(bus_addr);
          wr_log_d.push_back(bus_wdata);
          if (exp_wa.size() == 0)
            fail_now("unexpected_write", $sformatf("addr 0x%08h data 0x%08h, none required", bus_addr, bus_wdata));
          else begin
            check("wr_addr", bus_addr, exp_wa.pop_front());
            check("wr_data", bus_wdata, exp_wd.pop_front());
          end
        end
        if (prev_ov && !prev_or) begin
          check1("hold_valid", out_valid, 1'b1);
          check("hold_data", out_data, prev_od);
          check("hold_addr", bus_addr, prev_ba);
        end
        if (out_valid && out_ready) begin
          out_log.push_back(out_data);
          if (exp_od.size() == 0)
            fail_now("unexpected_out", $sformatf("data 0x%08h, none required", out_data));
          else
            check("out_data", out_data, exp_od.pop_front());
        end
        if (done) begin
          done_seen++;
          check1("done_busy", busy, 1'b1);
        end
        check1("done_pulse", prev_done & done, 1'b0);
        if (error) begin
          err_seen++;
          check1("error_idle", busy, 1'b0);
        end
        prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
        prev_ba = bus_addr;  prev_done = done;
      end
    end
  end

  task automatic pulse_start(input bit ld, input bit dp, input logic [31:0] b, input logic [5:0] n);
    if (!start_now) begin
      @(posedge clock); #1;
    end
    start_now = 0;
    base_addr = b; word_count = n; start_load = ld; start_dump = dp;
    @(posedge clock); #1;
    start_load = 0; start_dump = 0;
    base_addr = $urandom; word_count = 6'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_seen < exp_done && k < 100) begin
      @(posedge clock); k++;
    end
    @(posedge clock); @(posedge clock); #1;
    check("done_count", done_seen, exp_done);
    check("wr_queue_left", 32'(exp_wa.size()), 32'h0);
    check("out_queue_left", 32'(exp_od.size()), 32'h0);
    check1("idle_after", busy, 1'b0);
  endtask

  task automatic do_load(input logic [31:0] b, input int n, input bit poke);
    logic [31:0] w[$];
    logic [31:0] v;
    int i, cyc, bi;
    bit hs;
    bi = int'(b[6:2]);
    for (int k = 0; k < n; k++) begin
      v = (fixed.size() > 0) ? fixed.pop_front() : $urandom;
      w.push_back(v);
      exp_wa.push_back(32'(((bi + k) % 32) * 4));
      exp_wd.push_back(v);
      ref_mem[(bi + k) % 32] = v;
    end
    exp_done++;
    pulse_start(1'b1, 1'b0, b, 6'(n));
    check1("load_accept", busy, 1'b1);
    i = 0; cyc = 0;
    in_valid = ($urandom % 4) != 0;
    in_data = w[0];
    while (i < n && cyc < 2000) begin
      @(negedge clock); hs = in_valid && in_ready;
      @(posedge clock); #1; cyc++;
      if (hs) i++;
      in_valid = (i < n) && ($urandom % 4 != 0);
      in_data  = (i < n) ? w[i] : $urandom;
      // Valid-looking starts while busy must be ignored without error.
      start_dump = poke && (cyc == 1);
      start_load = poke && (cyc == 2);
      if (poke) begin base_addr = 32'h0; word_count = 6'd1; end
    end
    in_valid = 0; start_load = 0; start_dump = 0;
    if (i < n) fail_now("load_timeout", $sformatf("%0d of %0d words taken", i, n));
    wait_done();
  endtask

  task automatic do_dump(input logic [31:0] b, input int n, input bit bp);
    int got, cyc, held, bi;
    bit hs;
    logic [31:0] d0, a0;
    got = 0; cyc = 0; held = 0; d0 = 0; a0 = 0;
    bi = int'(b[6:2]);
    for (int k = 0; k < n; k++) exp_od.push_back(ref_mem[(bi + k) % 32]);
    exp_done++;
    out_ready = bp ? 1'b0 : 1'($urandom % 2);
    pulse_start(1'b0, 1'b1, b, 6'(n));
    check1("dump_accept", busy, 1'b1);
    while (got < n && cyc < 4000) begin
      @(negedge clock); hs = out_valid && out_ready;
      if (bp && got == 0 && out_valid && !out_ready) begin
        if (held == 0) begin d0 = out_data; a0 = bus_addr; end
        else begin
          check("bp_data", out_data, d0);
          check("bp_addr", bus_addr, a0);
        end
        held++;
      end
      @(posedge clock); #1; cyc++;
      if (hs) got++;
      if (bp) out_ready = !(got == 0 && held < 10);
      else    out_ready = ($urandom % 3) != 0;
    end
    out_ready = 0;
    if (got < n) fail_now("dump_timeout", $sformatf("%0d of %0d words out", got, n));
    if (bp) check("bp_cycles", 32'(held), 32'd10);
    wait_done();
  endtask

  task automatic do_err(input bit ld, input bit dp, input logic [31:0] b, input logic [5:0] n);
    int wr_before;
    wr_before = wr_log_a.size();
    busy_seen = 0;
    exp_err++;
    pulse_start(ld, dp, b, n);
    repeat (3) @(posedge clock);
    #1;
    check("err_count", err_seen, exp_err);
    check1("err_busy", busy_seen, 1'b0);
    check("err_no_write", 32'(wr_log_a.size()), 32'(wr_before));
  endtask

  task automatic do_reset_mid_load();
    logic [31:0] w[4];
    int i, cyc, d0;
    bit hs;
    d0 = done_seen;
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    for (int k = 0; k < 2; k++) begin
      exp_wa.push_back(32'((16 + k) * 4));
      exp_wd.push_back(w[k]);
      ref_mem[16 + k] = w[k];
    end
    pulse_start(1'b1, 1'b0, 32'h40, 6'd4);
    i = 0; cyc = 0;
    in_valid = 1; in_data = w[0];
    while (i < 2 && cyc < 100) begin
      @(negedge clock); hs = in_valid && in_ready;
      @(posedge clock); #1; cyc++;
      if (hs) i++;
      in_data = w[i];
      in_valid = (i < 2);
    end
    in_valid = 0;
    @(posedge clock); #1;
    check1("pre_reset_ready", in_ready, 1'b1);
    #2 reset = 1;
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    @(posedge clock); @(posedge clock); #1;
    check("rst_no_done", done_seen, d0);
    check("rst_writes", 32'(exp_wa.size()), 32'h0);
    start_now = 1;
    reset = 0;
    do_dump(32'h40, 2, 1'b0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: run did not end, %0d failures so far", fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, n;
    logic [31:0] b;
    for (int k = 0; k < 32; k++) ref_mem[k] = 32'h0;

    repeat (3) @(posedge clock);
    #1;
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_error", error, 1'b0);
    check1("reset_in_ready", in_ready, 1'b0);
    check1("reset_out_valid", out_valid, 1'b0);
    check1("reset_bus_we", bus_we, 1'b0);
    check("reset_bus_addr", bus_addr, 32'h0);
    check("reset_bus_wdata", bus_wdata, 32'h0);
    check("reset_out_data", out_data, 32'h0);

    // Load base 0x10, three words; start on the first edge after reset.
    start_now = 1;
    reset = 0;
    wr_log_a.delete(); wr_log_d.delete();
    fixed = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    do_load(32'h10, 3, 1'b0);
    check("ld3_nwrites", 32'(wr_log_a.size()), 32'd3);
    if (wr_log_a.size() == 3) begin
      check("ld3_a0", wr_log_a[0], 32'h10);
      check("ld3_a1", wr_log_a[1], 32'h14);
      check("ld3_a2", wr_log_a[2], 32'h18);
      check("ld3_d0", wr_log_d[0], 32'hAAAA_0001);
      check("ld3_d2", wr_log_d[2], 32'hCCCC_0003);
    end

    // Dump of idx 4..5.
    fixed = '{32'h1111_1111, 32'h2222_2222};
    do_load(32'h10, 2, 1'b0);
    out_log.delete();
    do_dump(32'h10, 2, 1'b0);
    check("dp2_nwords", 32'(out_log.size()), 32'd2);
    if (out_log.size() == 2) begin
      check("dp2_w0", out_log[0], 32'h1111_1111);
      check("dp2_w1", out_log[1], 32'h2222_2222);
    end

    // Wrap past the top of the memory.
    wr_log_a.delete(); wr_log_d.delete();
    do_load(32'h7C, 2, 1'b0);
    check("wrap_nwrites", 32'(wr_log_a.size()), 32'd2);
    if (wr_log_a.size() == 2) begin
      check("wrap_a0", wr_log_a[0], 32'h7C);
      check("wrap_a1", wr_log_a[1], 32'h00);
    end

    // Rejected starts.
    do_err(1'b1, 1'b0, 32'h82, 6'd4);
    do_err(1'b1, 1'b0, 32'h00, 6'd0);
    do_err(1'b0, 1'b1, 32'h00, 6'd33);
    do_err(1'b1, 1'b1, 32'h00, 6'd1);
    do_err(1'b0, 1'b1, 32'h80, 6'd1);

    // Backpressure: idx 4,5,6 = 0x11111111, 0x22222222, 0xCCCC0003.
    out_log.delete();
    do_dump(32'h10, 3, 1'b1);
    if (out_log.size() == 3) check("bp_w2", out_log[2], 32'hCCCC_0003);
    else fail_now("bp_nwords", $sformatf("got %0d words, required 3", out_log.size()));

    do_reset_mid_load();

    // Randomized traffic over a fully initialised memory.
    do_load(32'h0, 32, 1'b1);
    repeat (30) begin
      r = $urandom % 10;
      b = 32'(($urandom % 32) * 4);
      n = 1 + ($urandom % 32);
      if (r < 2) begin
        case ($urandom % 5)
          0: do_err(1'b1, 1'b0, b | 32'(1 + $urandom % 3), 6'(n));
          1: do_err(1'b0, 1'b1, b | (32'h80 << ($urandom % 25)), 6'(n));
          2: do_err(1'b1, 1'b0, b, 6'd0);
          3: do_err(1'b0, 1'b1, b, 6'(33 + $urandom % 31));
          default: do_err(1'b1, 1'b1, b, 6'(n));
        endcase
      end else if (r < 6) begin
        do_load(b, n, (n >= 2) && ($urandom % 2 == 1));
      end else begin
        do_dump(b, n, 1'b0);
      end
    end

    check("err_total", err_seen, exp_err);
    check("done_total", done_seen, exp_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_loader.md
DMEM_LOADER -- requirements
Module: dmem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 32, the data-memory depth in words, so word index is 5 bits.
REQ-002 Parameter READ_LAT, default 1, the number of cycles from bus_addr presented to bus_rdata valid.
REQ-003 Port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 Port start_load, input, 1 bit, a one-cycle request to write word_count host words into memory.
REQ-006 Port start_dump, input, 1 bit, a one-cycle request to read word_count memory words out to the host.
REQ-007 Port base_addr, input, 32 bits, the byte address of the first word, sampled at start.
REQ-008 Port word_count, input, 6 bits, the transfer length in words (1..MAX_WORDS), sampled at start.
REQ-009 Ports in_valid (input, 1), in_data (input, 32) and in_ready (output, 1) form the host-to-loader word stream.
REQ-010 Ports out_valid (output, 1), out_data (output, 32) and out_ready (input, 1) form the loader-to-host word stream.
REQ-011 Ports bus_addr (output, 32), bus_wdata (output, 32) and bus_we (output, 1) form the data-memory initiator bus.
REQ-012 Port bus_rdata, input, 32 bits, carries the data-memory read data.
REQ-013 Port busy, output, 1 bit, is high in every state except IDLE.
REQ-014 Port done, output, 1 bit, is a one-cycle pulse on successful completion.
REQ-015 Port error, output, 1 bit, is a one-cycle pulse on a rejected start.

Function
REQ-016 The loader SHALL implement states IDLE, LD_WAIT, LD_WRITE, DP_ADDR, DP_WAIT, DP_OUT and FINISH.
REQ-017 In IDLE, a start SHALL be rejected with an error pulse and the loader SHALL stay in IDLE if any of these hold: base_addr[1:0]!=0, base_addr[31:7]!=0, word_count==0, word_count>MAX_WORDS, or both starts are high.
REQ-018 A valid start_load SHALL latch the base and count, clear idx, and enter LD_WAIT on the next cycle.
REQ-019 In LD_WAIT, in_ready SHALL be 1, and when in_valid&in_ready the loader SHALL register in_data and go to LD_WRITE.
REQ-020 LD_WRITE SHALL last exactly one cycle, with bus_we=1, bus_addr={25'b0, idx, 2'b00} and bus_wdata=the registered word.
REQ-021 From LD_WRITE, idx SHALL increment and the loader SHALL return to LD_WAIT, or go to FINISH when idx==count-1.
REQ-022 A valid start_dump SHALL enter DP_ADDR, which drives bus_addr for idx, then DP_WAIT for READ_LAT cycles, then captures bus_rdata into out_data.
REQ-023 In DP_OUT, out_valid SHALL be 1 and out_data SHALL hold stable until out_ready.
REQ-024 On the out_ready handshake, the loader SHALL go to DP_ADDR for idx+1, or to FINISH after the last word.
REQ-025 FINISH SHALL pulse done for one cycle and then return to IDLE.
REQ-026 The word index SHALL wrap modulo 32 (base index + idx), so bus_addr[7] is never 1 and the I/O space is never touched.
REQ-027 bus_we SHALL be 0 in every state except LD_WRITE.
REQ-028 in_ready SHALL be 0 outside LD_WAIT.
REQ-029 out_valid SHALL be 0 outside DP_OUT.
REQ-030 Starts arriving while busy SHALL be ignored, with no error pulse.
REQ-031 Host stalls (in_valid=0 or out_ready=0) SHALL be tolerated indefinitely, with no timeout.

Reset
REQ-032 Reset SHALL asynchronously force state=IDLE and clear idx, in_ready, out_valid, bus_we, done, error, busy, and drive bus_addr, bus_wdata and out_data to 0.
REQ-033 A reset asserted mid-transfer SHALL abort the transfer, SHALL leave already-written words in memory, and SHALL produce no done pulse.
REQ-034 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-035 The state encoding, MAX_WORDS and the I/O address-space bit index (7) SHALL live in a shared package that is also used by the data-memory decode.
REQ-036 There SHALL be one sub-module, dmem_loader_addrgen, which computes the wrapped word address from the base and idx.

Verification
REQ-037 Load: base=0x10, count=3, words A,B,C -> bus_we pulses with addresses 0x10, 0x14, 0x18 carrying A, B, C, then a done pulse.
REQ-038 Dump: memory idx 4..5 = 0x11111111 and 0x22222222, base=0x10, count=2, out_ready=1 -> out_data sequence 0x11111111, 0x22222222, then done.
REQ-039 Wrap: base=0x7C, count=2 -> write addresses 0x7C then 0x00, with bus_addr[7]=0 throughout.
REQ-040 Errors: base=0x82, count=0, count=33, and both starts together -> each gives an error pulse, busy=0 and no bus_we.
REQ-041 Backpressure: during a dump, out_ready held low for 10 cycles -> out_data is stable and the address does not advance.
REQ-042 Reset during LD_WAIT of word 2 -> IDLE immediately, bus_we=0, no done pulse, and words 0..1 are retained in memory.
